// File: rtl/config_pkg.sv
// Shared config-memory definitions: field ids, header layout, error codes,
// and per-field width/depth lookups used by both the loader and the reader.
package config_pkg;

    localparam int NUM_CFG_FIELDS = 11;
    localparam logic [3:0] NUM_FID = 4'd11;

    localparam logic [3:0] FLD_LTP_WIN    = 4'd0;
    localparam logic [3:0] FLD_LTD_WIN    = 4'd1;
    localparam logic [3:0] FLD_LTP_LRNRT  = 4'd2;
    localparam logic [3:0] FLD_LTD_LRNRT  = 4'd3;
    localparam logic [3:0] FLD_LRN_BIAS   = 4'd4;
    localparam logic [3:0] FLD_NURN_TYPE  = 4'd5;
    localparam logic [3:0] FLD_RAND_TH    = 4'd6;
    localparam logic [3:0] FLD_TH_MASK    = 4'd7;
    localparam logic [3:0] FLD_RST_POT    = 4'd8;
    localparam logic [3:0] FLD_SPIKE_AER  = 4'd9;
    localparam logic [3:0] FLD_LRN_WGHT   = 4'd10;

    // Header layout: [31:28] field id, [27:16] len-1, [15:0] start address
    localparam int HDR_FID_LSB  = 28;
    localparam int HDR_FID_W    = 4;
    localparam int HDR_LEN_LSB  = 16;
    localparam int HDR_LEN_W    = 12;
    localparam int HDR_ADDR_LSB = 0;
    localparam int HDR_ADDR_W   = 16;

    typedef enum logic [1:0] {
        ERR_NONE  = 2'b00,
        ERR_FIELD = 2'b01,
        ERR_START = 2'b10,
        ERR_OVFL  = 2'b11
    } err_code_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WRITE,
        S_DRAIN,
        S_DONE
    } ld_state_e;

    // Number of meaningful data bits stored by each field
    function automatic int field_width(input logic [3:0] fid, input int win_w,
                                       input int dsize, input int aer);
        int w;
        case (fid)
            FLD_LTP_WIN, FLD_LTD_WIN:                        w = win_w;
            FLD_LTP_LRNRT, FLD_LTD_LRNRT,
            FLD_TH_MASK, FLD_RST_POT:                        w = dsize;
            FLD_LRN_BIAS, FLD_NURN_TYPE, FLD_RAND_TH,
            FLD_LRN_WGHT:                                    w = 1;
            FLD_SPIKE_AER:                                   w = aer;
            default:                                         w = 0;
        endcase
        return w;
    endfunction

    // Number of addressable entries in each field's RAM
    function automatic int field_depth(input logic [3:0] fid, input int nurns, input int axons);
        int d;
        if (fid == FLD_LRN_WGHT)  d = nurns * axons;
        else if (fid < NUM_FID)   d = nurns;
        else                      d = 0;
        return d;
    endfunction

endpackage

// File: rtl/cfg_hdr_decode.sv
// Combinational header decode: field one-hot, burst length, start address,
// field depth, data mask and header error classification.
import config_pkg::*;

module cfg_hdr_decode #(
    parameter int NUM_NURNS          = 256,
    parameter int NUM_AXONS          = 256,
    parameter int DSIZE              = 16,
    parameter int STDP_WIN_BIT_WIDTH = 8,
    parameter int AER_BIT_WIDTH      = 32,
    parameter int ADDR_W             = 16
) (
    input  logic [AER_BIT_WIDTH-1:0]   hdr,
    output logic [NUM_CFG_FIELDS-1:0]  field_oh,
    output logic [HDR_LEN_W-1:0]       len_m1,
    output logic [HDR_ADDR_W-1:0]      start,
    output logic [ADDR_W:0]            depth,
    output logic [AER_BIT_WIDTH-1:0]   mask,
    output err_code_e                  err
);
    typedef logic [ADDR_W:0] depth_t;

    logic [HDR_FID_W-1:0] fid;
    int                   width;

    // Split header, look up field geometry and classify errors
    always_comb begin
        fid      = hdr[HDR_FID_LSB +: HDR_FID_W];
        len_m1   = hdr[HDR_LEN_LSB +: HDR_LEN_W];
        start    = hdr[HDR_ADDR_LSB +: HDR_ADDR_W];
        width    = field_width(fid, STDP_WIN_BIT_WIDTH, DSIZE, AER_BIT_WIDTH);
        depth    = depth_t'(field_depth(fid, NUM_NURNS, NUM_AXONS));
        field_oh = '0;
        if (fid < NUM_FID)
            field_oh[fid] = 1'b1;
        for (int i = 0; i < AER_BIT_WIDTH; i++)
            mask[i] = (i < width);
        if (fid >= NUM_FID)
            err = ERR_FIELD;
        else if (depth_t'(start) >= depth)
            err = ERR_START;
        else
            err = ERR_NONE;
    end

endmodule

// File: rtl/config_mem_loader.sv
// Config word-stream loader: parses a header, then turns the following burst
// into registered, width-masked, auto-incrementing writes to the config RAMs.
import config_pkg::*;

module config_mem_loader #(
    parameter int NUM_NURNS          = 256,
    parameter int NUM_AXONS          = 256,
    parameter int DSIZE              = 16,
    parameter int NURN_CNT_BIT_WIDTH = 8,
    parameter int AXON_CNT_BIT_WIDTH = 8,
    parameter int STDP_WIN_BIT_WIDTH = 8,
    parameter int AER_BIT_WIDTH      = 32
) (
    input  logic                                         clk_i,
    input  logic                                         rst_i,
    input  logic [AER_BIT_WIDTH-1:0]                     cfg_data_i,
    input  logic                                         cfg_valid_i,
    output logic                                         cfg_ready_o,
    output logic [NUM_CFG_FIELDS-1:0]                    wr_en_o,
    output logic [NURN_CNT_BIT_WIDTH+AXON_CNT_BIT_WIDTH-1:0] wr_addr_o,
    output logic [AER_BIT_WIDTH-1:0]                     wr_data_o,
    output logic                                         busy_o,
    output logic                                         done_o,
    output logic                                         err_o,
    output logic [1:0]                                   err_code_o
);
    localparam int ADDR_W = NURN_CNT_BIT_WIDTH + AXON_CNT_BIT_WIDTH;
    typedef logic [ADDR_W:0] addr_t;   // one spare bit so "reached depth" is visible

    ld_state_e                   state, state_nxt;
    logic [NUM_CFG_FIELDS-1:0]   dec_oh, fld_q;
    logic [HDR_LEN_W-1:0]        dec_len, cnt_q;
    logic [HDR_ADDR_W-1:0]       dec_start;
    addr_t                       dec_depth, depth_q, addr_q;
    logic [AER_BIT_WIDTH-1:0]    dec_mask, mask_q;
    err_code_e                   dec_err;
    logic                        pkt_err_q;
    logic                        accept, last, ovf;

    cfg_hdr_decode #(
        .NUM_NURNS          (NUM_NURNS),
        .NUM_AXONS          (NUM_AXONS),
        .DSIZE              (DSIZE),
        .STDP_WIN_BIT_WIDTH (STDP_WIN_BIT_WIDTH),
        .AER_BIT_WIDTH      (AER_BIT_WIDTH),
        .ADDR_W             (ADDR_W)
    ) u_dec (
        .hdr      (cfg_data_i),
        .field_oh (dec_oh),
        .len_m1   (dec_len),
        .start    (dec_start),
        .depth    (dec_depth),
        .mask     (dec_mask),
        .err      (dec_err)
    );

    assign cfg_ready_o = !rst_i && (state != S_DONE);
    assign accept      = cfg_valid_i && cfg_ready_o;
    assign last        = (cnt_q == '0);
    assign ovf         = (addr_q >= depth_q);
    assign busy_o      = (state != S_IDLE);
    assign done_o      = (state == S_DONE);
    assign err_o       = (state == S_DONE) && pkt_err_q;

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // Next-state: header picks WRITE/DRAIN, burst end goes to a 1-cycle DONE
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (accept) state_nxt = (dec_err == ERR_NONE) ? S_WRITE : S_DRAIN;
            S_WRITE: if (accept) state_nxt = last ? S_DONE : (ovf ? S_DRAIN : S_WRITE);
            S_DRAIN: if (accept && last) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Burst counters, latched header info and registered write port
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q      <= '0;
            addr_q     <= '0;
            fld_q      <= '0;
            mask_q     <= '0;
            depth_q    <= '0;
            pkt_err_q  <= 1'b0;
            wr_en_o    <= '0;
            wr_addr_o  <= '0;
            wr_data_o  <= '0;
            err_code_o <= '0;
        end else begin
            wr_en_o <= '0;
            if (accept) begin
                case (state)
                    S_IDLE: begin
                        cnt_q     <= dec_len;
                        addr_q    <= addr_t'(dec_start);
                        fld_q     <= dec_oh;
                        mask_q    <= dec_mask;
                        depth_q   <= dec_depth;
                        pkt_err_q <= (dec_err != ERR_NONE);
                        if (dec_err != ERR_NONE)
                            err_code_o <= dec_err;
                    end
                    S_WRITE: begin
                        cnt_q  <= cnt_q - 1'b1;
                        addr_q <= addr_q + 1'b1;
                        if (ovf) begin
                            pkt_err_q  <= 1'b1;
                            err_code_o <= ERR_OVFL;
                        end else begin
                            wr_en_o   <= fld_q;
                            wr_addr_o <= addr_q[ADDR_W-1:0];
                            wr_data_o <= cfg_data_i & mask_q;
                        end
                    end
                    S_DRAIN: cnt_q <= cnt_q - 1'b1;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_config_mem_loader.sv
// Directed bench for config_mem_loader: header/burst scenarios with
// hand-computed write sequences, error codes and handshake timing.
module tb_config_mem_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] cfg_data;
    logic        cfg_valid;
    logic        cfg_ready_o;
    logic [10:0] wr_en_o;
    logic [15:0] wr_addr_o;
    logic [31:0] wr_data_o;
    logic        busy_o, done_o, err_o;
    logic [1:0]  err_code_o;

    int checks = 0;
    int failures = 0;
    int done_cnt = 0, err_cnt = 0, rdy_low = 0;
    int d0, e0, r0;
    logic [31:0] q_en[$], q_addr[$], q_data[$];

    always #5 clk = ~clk;

    config_mem_loader dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .cfg_data_i  (cfg_data),
        .cfg_valid_i (cfg_valid),
        .cfg_ready_o (cfg_ready_o),
        .wr_en_o     (wr_en_o),
        .wr_addr_o   (wr_addr_o),
        .wr_data_o   (wr_data_o),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .err_o       (err_o),
        .err_code_o  (err_code_o)
    );

    // Log every write strobe and count done/err pulses and ready-low cycles
    always @(negedge clk) begin
        if (wr_en_o != '0) begin
            q_en.push_back({21'd0, wr_en_o});
            q_addr.push_back({16'd0, wr_addr_o});
            q_data.push_back(wr_data_o);
        end
        if (done_o) done_cnt++;
        if (err_o) err_cnt++;
        if (!rst && !cfg_ready_o) rdy_low++;
    end

    function automatic logic [31:0] hdr(input int fid, input int len_m1, input int addr);
        return {4'(fid), 12'(len_m1), 16'(addr)};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [31:0] w);
        int g;
        g = 0;
        cfg_data  = w;
        cfg_valid = 1'b1;
        #1;
        while (!cfg_ready_o && g < 20) begin
            @(negedge clk);
            #1;
            g++;
        end
        chk("send_accept_timeout", 32'(g < 20), 32'd1);
        @(posedge clk);
        @(negedge clk);
        cfg_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        cfg_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic chk_wr(input string tag, input logic [31:0] en,
                          input logic [31:0] addr, input logic [31:0] data);
        if (q_en.size() == 0) begin
            chk({tag, "_present"}, 32'd0, 32'd1);
        end else begin
            chk({tag, "_en"},   q_en.pop_front(),   en);
            chk({tag, "_addr"}, q_addr.pop_front(), addr);
            chk({tag, "_data"}, q_data.pop_front(), data);
        end
    endtask

    task automatic snap();
        d0 = done_cnt; e0 = err_cnt; r0 = rdy_low;
    endtask

    initial begin
        rst = 1'b1; cfg_valid = 1'b0; cfg_data = '0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_ready",   32'(cfg_ready_o), 32'd0);
        chk("rst_wr_en",   32'(wr_en_o),     32'd0);
        chk("rst_busy",    32'(busy_o),      32'd0);
        chk("rst_done",    32'(done_o),      32'd0);
        chk("rst_err",     32'(err_o),       32'd0);
        chk("rst_errcode", 32'(err_code_o),  32'd0);
        rst = 1'b0;
        @(negedge clk); #1;
        chk("ready_after_rst", 32'(cfg_ready_o), 32'd1);

        // 1: Th_Mask burst of 3, 16-bit mask
        snap();
        send(hdr(7, 2, 5));
        chk("t1_busy", 32'(busy_o), 32'd1);
        send(32'h1234ABCD); send(32'h0000FFFF); send(32'h7);
        idle(3);
        chk_wr("t1_w0", 32'h080, 32'd5, 32'h0000ABCD);
        chk_wr("t1_w1", 32'h080, 32'd6, 32'h0000FFFF);
        chk_wr("t1_w2", 32'h080, 32'd7, 32'h00000007);
        chk("t1_extra_wr", q_en.size(), 32'd0);
        chk("t1_done", done_cnt - d0, 32'd1);
        chk("t1_err",  err_cnt - e0,  32'd0);

        // 2: LrnModeWght single word at the last address, 1-bit mask, write latency
        snap();
        send(hdr(10, 0, 16'hFFFF));
        send(32'hFFFFFFFF);
        chk("t2_wr_en_lat", 32'(wr_en_o),   32'h400);
        chk("t2_addr",      32'(wr_addr_o), 32'h0000FFFF);
        chk("t2_data",      wr_data_o,      32'h1);
        chk("t2_done",      32'(done_o),    32'd1);
        idle(3);
        q_en.delete(); q_addr.delete(); q_data.delete();
        chk("t2_err", err_cnt - e0, 32'd0);

        // 3: bad field id 12, both data words drained
        snap();
        send(hdr(12, 1, 0));
        chk("t3_busy_drain", 32'(busy_o), 32'd1);
        send(32'h11111111); send(32'h22222222);
        chk("t3_done", 32'(done_o), 32'd1);
        chk("t3_err",  32'(err_o),  32'd1);
        idle(3);
        chk("t3_no_wr",  q_en.size(), 32'd0);
        chk("t3_code",   32'(err_code_o), 32'h1);

        // 4: LTP_Win burst crossing the end of the field
        snap();
        send(hdr(0, 3, 254));
        send(32'h1FF); send(32'h2AB); send(32'h3CD); send(32'h4EF);
        idle(3);
        chk_wr("t4_w0", 32'h001, 32'd254, 32'hFF);
        chk_wr("t4_w1", 32'h001, 32'd255, 32'hAB);
        chk("t4_no_more", q_en.size(), 32'd0);
        chk("t4_code", 32'(err_code_o), 32'h3);
        chk("t4_done", done_cnt - d0, 32'd1);
        chk("t4_err",  err_cnt - e0,  32'd1);

        // 4b: start address equal to depth
        snap();
        send(hdr(5, 0, 256));
        send(32'h1);
        idle(3);
        chk("t4b_no_wr", q_en.size(), 32'd0);
        chk("t4b_code",  32'(err_code_o), 32'h2);
        chk("t4b_err",   err_cnt - e0, 32'd1);

        // 5: scenario 1 with random valid gaps
        snap();
        send(hdr(7, 2, 5)); idle($urandom_range(0, 3));
        send(32'h1234ABCD); idle($urandom_range(1, 3));
        send(32'h0000FFFF); idle($urandom_range(1, 3));
        send(32'h7);
        idle(3);
        chk_wr("t5_w0", 32'h080, 32'd5, 32'h0000ABCD);
        chk_wr("t5_w1", 32'h080, 32'd6, 32'h0000FFFF);
        chk_wr("t5_w2", 32'h080, 32'd7, 32'h00000007);
        chk("t5_done", done_cnt - d0, 32'd1);
        chk("t5_code_held", 32'(err_code_o), 32'h2);

        // 5b: reset mid-burst, next word must be parsed as a header
        snap();
        send(hdr(7, 3, 0));
        send(32'h11);
        rst = 1'b1;
        @(negedge clk); #1;
        chk("t5r_wr_en",   32'(wr_en_o),    32'd0);
        chk("t5r_busy",    32'(busy_o),     32'd0);
        chk("t5r_code",    32'(err_code_o), 32'd0);
        chk("t5r_ready",   32'(cfg_ready_o), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        send(hdr(8, 0, 3));
        send(32'hFFFF1234);
        chk("t5r_new_en",   32'(wr_en_o),   32'h100);
        chk("t5r_new_addr", 32'(wr_addr_o), 32'd3);
        chk("t5r_new_data", wr_data_o,      32'h1234);
        idle(3);
        chk_wr("t5r_w0", 32'h080, 32'd0, 32'h11);
        chk_wr("t5r_w1", 32'h100, 32'd3, 32'h1234);
        chk("t5r_done", done_cnt - d0, 32'd1);
        chk("t5r_err",  err_cnt - e0,  32'd0);

        // 6: back-to-back packets, ready low one DONE cycle per packet
        snap();
        send(hdr(2, 1, 10));
        send(32'hAAAA5555); send(32'h1);
        send(hdr(9, 0, 32'h20));
        send(32'hDEADBEEF);
        idle(3);
        chk_wr("t6_w0", 32'h004, 32'd10,   32'h5555);
        chk_wr("t6_w1", 32'h004, 32'd11,   32'h0001);
        chk_wr("t6_w2", 32'h200, 32'h20,   32'hDEADBEEF);
        chk("t6_ready_low", rdy_low - r0,  32'd2);
        chk("t6_done",      done_cnt - d0, 32'd2);
        chk("t6_err",       err_cnt - e0,  32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
